// File: rtl/scanline_renderer_if.sv
// Line-buffer write port: one-hot buffer select, pixel address and data, with a grant from the buffer side.
// A write completes on any cycle where a vram_we bit and vram_grant are both high.
interface scanline_renderer_if #(
  parameter int LINE_BUFS = 2,
  parameter int ADDR_W    = 10,
  parameter int PIXEL_W   = 8
);
  logic [LINE_BUFS-1:0] vram_we;
  logic [ADDR_W-1:0]    vram_addr;
  logic [PIXEL_W-1:0]   vram_d;
  logic                 vram_grant;

  modport master (output vram_we, vram_addr, vram_d, input vram_grant);
  modport slave  (input vram_we, vram_addr, vram_d, output vram_grant);
endinterface

// File: rtl/scanline_renderer.sv
// Renders one scanline of a procedural pattern into rotating line buffers, one pixel per granted cycle.
// Optional SCANLINE_RENDERER_OVERRUN_CNT_EN adds a saturating 16-bit overrun counter output.
module scanline_renderer #(
  parameter int H_PIXELS  = 800,
  parameter int V_PIXELS  = 600,
  parameter int PIXEL_W   = 8,
  parameter int LINE_BUFS = 2,
  parameter int FRAME_W   = 6,
  parameter int BAND_LO   = 111,
  parameter int BAND_HI   = 333,
  localparam int ADDR_W   = $clog2(H_PIXELS),
  localparam int V_CW     = $clog2(V_PIXELS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_start,
  input  logic [V_CW-1:0]    line_v,
  input  logic               frame_start,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] fg_color,
  input  logic [PIXEL_W-1:0] bg_color,
  scanline_renderer_if.master vram,
  output logic               busy,
  output logic               line_done,
  output logic               overrun
`ifdef SCANLINE_RENDERER_OVERRUN_CNT_EN
  , output logic [15:0]      overrun_cnt
`endif
);

  localparam int LB_W  = $clog2(LINE_BUFS);
  localparam int MAX_W = (ADDR_W > V_CW) ? ((ADDR_W > FRAME_W) ? ADDR_W : FRAME_W)
                                         : ((V_CW > FRAME_W) ? V_CW : FRAME_W);
  localparam int S_W   = MAX_W + 2;

  typedef enum logic {S_IDLE, S_RENDER} state_t;

  state_t               state_q, state_d;
  logic [LINE_BUFS-1:0] we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [PIXEL_W-1:0]   dat_q, dat_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [FRAME_W-1:0]   line_frame_q, line_frame_d;
  logic [V_CW-1:0]      line_v_q, line_v_d;
  logic [1:0]           mode_q, mode_d;
  logic [PIXEL_W-1:0]   fg_q, fg_d, bg_q, bg_d;
  logic                 accept;

  function automatic logic [PIXEL_W-1:0] pix_f(
    input logic [1:0]         m,
    input logic [ADDR_W-1:0]  x,
    input logic [V_CW-1:0]    v,
    input logic [FRAME_W-1:0] f,
    input logic [PIXEL_W-1:0] fg,
    input logic [PIXEL_W-1:0] bg
  );
    logic [S_W-1:0]     s;
    logic [PIXEL_W-1:0] p;
    // Sum is widened by two bits so it can never wrap back into the band.
    s = S_W'(x) + S_W'(v) + S_W'(f);
    case (m)
      2'd0:    p = fg;
      2'd1:    p = (s >= S_W'(BAND_LO) && s <= S_W'(BAND_HI)) ? fg : bg;
      2'd2:    p = (x[3] ^ v[3]) ? fg : bg;
      default: p = PIXEL_W'(x);
    endcase
    return p;
  endfunction

  assign accept = (|we_q) && vram.vram_grant;

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    dat_d        = dat_q;
    done_d       = 1'b0;
    overrun_d    = 1'b0;
    frame_d      = frame_q + FRAME_W'(frame_start);
    line_frame_d = line_frame_q;
    line_v_d     = line_v_q;
    mode_d       = mode_q;
    fg_d         = fg_q;
    bg_d         = bg_q;
    if (line_start) begin
      overrun_d = (state_q == S_RENDER);
      if ({1'b0, line_v} < (V_CW + 1)'(V_PIXELS)) begin
        state_d      = S_RENDER;
        line_frame_d = frame_d;
        line_v_d     = line_v;
        mode_d       = mode;
        fg_d         = fg_color;
        bg_d         = bg_color;
        we_d         = LINE_BUFS'(1) << line_v[LB_W-1:0];
        addr_d       = '0;
        dat_d        = pix_f(mode, '0, line_v, frame_d, fg_color, bg_color);
      end else begin
        state_d = S_IDLE;
        we_d    = '0;
        addr_d  = '0;
        dat_d   = '0;
      end
    end else if (accept) begin
      if (addr_q == ADDR_W'(H_PIXELS - 1)) begin
        state_d = S_IDLE;
        we_d    = '0;
        addr_d  = '0;
        dat_d   = '0;
        done_d  = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
        dat_d  = pix_f(mode_q, addr_q + ADDR_W'(1), line_v_q, line_frame_q, fg_q, bg_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= '0;
      addr_q       <= '0;
      dat_q        <= '0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
      frame_q      <= '0;
      line_frame_q <= '0;
      line_v_q     <= '0;
      mode_q       <= '0;
      fg_q         <= '0;
      bg_q         <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      dat_q        <= dat_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
      frame_q      <= frame_d;
      line_frame_q <= line_frame_d;
      line_v_q     <= line_v_d;
      mode_q       <= mode_d;
      fg_q         <= fg_d;
      bg_q         <= bg_d;
    end
  end

  assign vram.vram_we   = we_q;
  assign vram.vram_addr = addr_q;
  assign vram.vram_d    = dat_q;
  assign busy           = (state_q == S_RENDER);
  assign line_done      = done_q;
  assign overrun        = overrun_q;

`ifdef SCANLINE_RENDERER_OVERRUN_CNT_EN
  logic [15:0] ocnt_q, ocnt_d;

  always_comb begin
    ocnt_d = ocnt_q;
    if (overrun_q && ocnt_q != 16'hFFFF) ocnt_d = ocnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ocnt_q <= '0;
    else     ocnt_q <= ocnt_d;
  end

  assign overrun_cnt = ocnt_q;
`endif

endmodule

// File: tb/tb_scanline_renderer.sv
// Directed bench for scanline_renderer at default parameters; inputs change and outputs are sampled on the falling edge.
module tb_scanline_renderer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       line_start = 1'b0;
  logic [9:0] line_v = '0;
  logic       frame_start = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] fg_color = '0;
  logic [7:0] bg_color = '0;
  logic       busy, line_done, overrun;
  logic [15:0] overrun_cnt;
  int checks = 0;
  int failures = 0;

  scanline_renderer_if #(.LINE_BUFS(2), .ADDR_W(10), .PIXEL_W(8)) vif ();

  scanline_renderer dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_v(line_v),
    .frame_start(frame_start), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
    .vram(vif.master), .busy(busy), .line_done(line_done), .overrun(overrun)
`ifdef SCANLINE_RENDERER_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

`ifndef SCANLINE_RENDERER_OVERRUN_CNT_EN
  assign overrun_cnt = 16'h0;
`endif

  always #5 clk = ~clk;

  task automatic start_line(input logic [9:0] v, input logic [1:0] m,
                            input logic [7:0] fg, input logic [7:0] bg, input logic fs);
    @(negedge clk);
    line_start = 1'b1; line_v = v; mode = m; fg_color = fg; bg_color = bg; frame_start = fs;
    @(negedge clk);
    line_start = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_reset();
    vif.vram_grant = 1'b1;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({vif.vram_we, vif.vram_addr, vif.vram_d, busy, line_done, overrun} !== 23'd0) begin
      failures++;
      $display("FAIL reset_outputs: got we=%b addr=%0d d=%h busy=%b done=%b ovr=%b, want all 0",
               vif.vram_we, vif.vram_addr, vif.vram_d, busy, line_done, overrun);
    end
    rst = 1'b0;
  endtask

  task automatic test_solid();
    start_line(10'd5, 2'd0, 8'hAA, 8'h00, 1'b0);
    for (int i = 0; i < 800; i++) begin
      checks++;
      if (vif.vram_we !== 2'b10 || vif.vram_addr !== 10'(i) || vif.vram_d !== 8'hAA || busy !== 1'b1) begin
        failures++;
        $display("FAIL solid_px%0d: got we=%b addr=%0d d=%h busy=%b, want we=10 addr=%0d d=aa busy=1",
                 i, vif.vram_we, vif.vram_addr, vif.vram_d, busy, i);
      end
      @(negedge clk);
    end
    checks++;
    if (line_done !== 1'b1 || vif.vram_we !== 2'b00 || vif.vram_addr !== 10'd0 || vif.vram_d !== 8'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL solid_done: got done=%b we=%b addr=%0d d=%h busy=%b, want done=1 rest 0",
               line_done, vif.vram_we, vif.vram_addr, vif.vram_d, busy);
    end
    @(negedge clk);
    checks++;
    if (line_done !== 1'b0) begin
      failures++;
      $display("FAIL solid_done_pulse: got done=%b, want 0", line_done);
    end
  endtask

  task automatic test_band();
    int lo[3] = '{11, 10, 9};
    int hi[3] = '{233, 232, 231};
    logic fs[3] = '{1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      // Third pass gets its frame bump from a standalone frame_start pulse.
      if (k == 2) begin
        @(negedge clk); frame_start = 1'b1;
        @(negedge clk); frame_start = 1'b0;
      end
      start_line(10'd100, 2'd1, 8'hFF, 8'h00, fs[k]);
      for (int i = 0; i < 800; i++) begin
        logic [7:0] exp_d;
        exp_d = (i >= lo[k] && i <= hi[k]) ? 8'hFF : 8'h00;
        checks++;
        if (vif.vram_we !== 2'b01 || vif.vram_addr !== 10'(i) || vif.vram_d !== exp_d) begin
          failures++;
          $display("FAIL band%0d_px%0d: got we=%b addr=%0d d=%h, want we=01 addr=%0d d=%h",
                   k, i, vif.vram_we, vif.vram_addr, vif.vram_d, i, exp_d);
        end
        @(negedge clk);
      end
      checks++;
      if (line_done !== 1'b1) begin
        failures++;
        $display("FAIL band%0d_done: got %b, want 1", k, line_done);
      end
    end
  endtask

  task automatic test_checker();
    start_line(10'd8, 2'd2, 8'hF0, 8'h0F, 1'b0);
    for (int i = 0; i < 32; i++) begin
      logic [7:0] exp_d;
      exp_d = (((i / 8) % 2) == 0) ? 8'hF0 : 8'h0F;
      checks++;
      if (vif.vram_addr !== 10'(i) || vif.vram_d !== exp_d) begin
        failures++;
        $display("FAIL checker_px%0d: got addr=%0d d=%h, want addr=%0d d=%h",
                 i, vif.vram_addr, vif.vram_d, i, exp_d);
      end
      @(negedge clk);
    end
    for (int i = 32; i < 800; i++) @(negedge clk);
  endtask

  task automatic test_hgrad();
    start_line(10'd0, 2'd3, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 800; i++) begin
      if (i == 300) begin
        checks++;
        if (vif.vram_addr !== 10'd300 || vif.vram_d !== 8'h2C) begin
          failures++;
          $display("FAIL hgrad_300: got addr=%0d d=%h, want addr=300 d=2c", vif.vram_addr, vif.vram_d);
        end
      end
      if (i == 5 || i == 799) begin
        checks++;
        if (vif.vram_d !== ((i == 5) ? 8'h05 : 8'h1F)) begin
          failures++;
          $display("FAIL hgrad_px%0d: got d=%h", i, vif.vram_d);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_grant_stall();
    start_line(10'd0, 2'd0, 8'h55, 8'h00, 1'b0);
    for (int c = 1; c <= 803; c++) begin
      int exp_a;
      exp_a = (c <= 8) ? c - 1 : ((c <= 11) ? 7 : c - 4);
      checks++;
      if (vif.vram_we !== 2'b01 || vif.vram_addr !== 10'(exp_a) || vif.vram_d !== 8'h55) begin
        failures++;
        $display("FAIL stall_cyc%0d: got we=%b addr=%0d d=%h, want we=01 addr=%0d d=55",
                 c, vif.vram_we, vif.vram_addr, vif.vram_d, exp_a);
      end
      vif.vram_grant = (c >= 8 && c <= 10) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    checks++;
    if (line_done !== 1'b1 || vif.vram_we !== 2'b00) begin
      failures++;
      $display("FAIL stall_done: got done=%b we=%b, want done=1 we=00", line_done, vif.vram_we);
    end
  endtask

  task automatic test_overrun();
    int dones;
    start_line(10'd3, 2'd0, 8'h11, 8'h00, 1'b0);
    for (int i = 0; i < 400; i++) @(negedge clk);
    checks++;
    if (vif.vram_addr !== 10'd400) begin
      failures++;
      $display("FAIL ovr_pre_addr: got %0d, want 400", vif.vram_addr);
    end
    line_start = 1'b1; line_v = 10'd2; fg_color = 8'h22;
    @(negedge clk);
    line_start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || vif.vram_addr !== 10'd0 || vif.vram_we !== 2'b01 ||
        vif.vram_d !== 8'h22 || line_done !== 1'b0) begin
      failures++;
      $display("FAIL ovr_restart: got ovr=%b addr=%0d we=%b d=%h done=%b, want ovr=1 addr=0 we=01 d=22 done=0",
               overrun, vif.vram_addr, vif.vram_we, vif.vram_d, line_done);
    end
    @(negedge clk);
    checks++;
    if (overrun !== 1'b0 || vif.vram_addr !== 10'd1) begin
      failures++;
      $display("FAIL ovr_pulse: got ovr=%b addr=%0d, want ovr=0 addr=1", overrun, vif.vram_addr);
    end
    dones = 0;
    for (int i = 0; i < 900; i++) begin
      if (line_done === 1'b1) dones++;
      @(negedge clk);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL ovr_done_count: got %0d, want 1", dones);
    end
`ifdef SCANLINE_RENDERER_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 16'd1) begin
      failures++;
      $display("FAIL ovr_cnt: got %0d, want 1", overrun_cnt);
    end
`endif
  endtask

  task automatic test_invalid_line();
    int bad;
    start_line(10'd600, 2'd0, 8'hAA, 8'h00, 1'b0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (vif.vram_we !== 2'b00 || busy !== 1'b0 || line_done !== 1'b0 || overrun !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL invalid_idle: %0d active cycles, want 0", bad);
    end
    start_line(10'd1, 2'd0, 8'hAA, 8'h00, 1'b0);
    @(negedge clk);
    line_start = 1'b1; line_v = 10'd700;
    @(negedge clk);
    line_start = 1'b0;
    checks++;
    if (overrun !== 1'b1 || vif.vram_we !== 2'b00 || busy !== 1'b0 || vif.vram_addr !== 10'd0) begin
      failures++;
      $display("FAIL invalid_abandon: got ovr=%b we=%b busy=%b addr=%0d, want ovr=1 we=00 busy=0 addr=0",
               overrun, vif.vram_we, busy, vif.vram_addr);
    end
    bad = 0;
    for (int i = 0; i < 900; i++) begin
      if (line_done !== 1'b0 || vif.vram_we !== 2'b00) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL invalid_no_done: %0d active cycles, want 0", bad);
    end
  endtask

  task automatic test_rst_midline();
    start_line(10'd4, 2'd3, 8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 50; i++) @(negedge clk);
    checks++;
    if (vif.vram_addr !== 10'd50 || vif.vram_d !== 8'd50) begin
      failures++;
      $display("FAIL rst_pre_addr: got addr=%0d d=%h, want addr=50 d=32", vif.vram_addr, vif.vram_d);
    end
    rst = 1'b1; line_start = 1'b1; line_v = 10'd6;
    @(negedge clk);
    checks++;
    if ({vif.vram_we, vif.vram_addr, vif.vram_d, busy, line_done, overrun} !== 23'd0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got we=%b addr=%0d d=%h busy=%b done=%b ovr=%b, want all 0",
               vif.vram_we, vif.vram_addr, vif.vram_d, busy, line_done, overrun);
    end
    rst = 1'b0; line_start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vif.vram_we !== 2'b00) begin
      failures++;
      $display("FAIL rst_ignores_start: got busy=%b we=%b, want 0 00", busy, vif.vram_we);
    end
  endtask

  initial begin
    vif.vram_grant = 1'b1;
    test_reset();
    test_solid();
    test_reset();
    test_band();
    test_checker();
    test_hgrad();
    test_grant_stall();
    test_reset();
    test_overrun();
    test_invalid_line();
    test_rst_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scanline_renderer.md
SCANLINE_RENDERER -- requirements
Module: scanline_renderer

Interface
REQ-001 Parameter H_PIXELS, default 800: pixels rendered per line.
REQ-002 Parameter V_PIXELS, default 600: visible lines; line_v values at or above this are not rendered.
REQ-003 Parameter PIXEL_W, default 8: bits per pixel.
REQ-004 Parameter LINE_BUFS, default 2, power of two >= 2: number of line buffers written in rotation.
REQ-005 Parameter FRAME_W, default 6: frame counter width.
REQ-006 Parameters BAND_LO = 111 and BAND_HI = 333: inclusive band limits for BAND mode.
REQ-007 Derived: ADDR_W = $clog2(H_PIXELS); V_CW = $clog2(V_PIXELS).
REQ-008 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-009 clk  in  1  sole clock; all state changes on its rising edge.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 line_start  in  1  one-cycle pulse requesting a line render.
REQ-012 line_v  in  V_CW  line number to render; sampled with line_start.
REQ-013 frame_start  in  1  one-cycle pulse; advances the frame counter.
REQ-014 mode  in  2  pattern: 0 SOLID, 1 BAND, 2 CHECKER, 3 HGRAD; sampled with line_start.
REQ-015 fg_color, bg_color  in  PIXEL_W each  pattern colours; sampled with line_start.
REQ-016 vram_grant  in  1  write port accepts the presented write this cycle.
REQ-017 vram_we  out  LINE_BUFS  one-hot write enable; bit = line_v mod LINE_BUFS.
REQ-018 vram_addr  out  ADDR_W  pixel x address.
REQ-019 vram_d  out  PIXEL_W  pixel data.
REQ-020 busy  out  1  high while in RENDER.
REQ-021 line_done  out  1  one-cycle pulse after the last pixel is accepted.
REQ-022 overrun  out  1  one-cycle pulse when line_start arrives while busy.

Function
REQ-023 States: IDLE and RENDER; line_start with line_v < V_PIXELS -> RENDER, x = 0.
REQ-024 Outputs are registered; the write for x = 0 is presented the cycle after line_start is sampled.
REQ-025 A write is accepted when any vram_we bit and vram_grant are high; vram_we, vram_addr and vram_d hold until acceptance.
REQ-026 After an accepted write with x < H_PIXELS-1, the next cycle presents x+1; throughput is one pixel per granted cycle.
REQ-027 Acceptance of x = H_PIXELS-1 -> IDLE, vram_we = 0 and line_done = 1 next cycle.
REQ-028 SOLID: pixel = fg_color.
REQ-029 BAND: s = x + line_v + frame, zero-extended to max(ADDR_W, V_CW, FRAME_W)+2 bits with no wrap; pixel = fg if BAND_LO <= s <= BAND_HI, else bg.
REQ-030 CHECKER: pixel = fg if x[3] XOR line_v[3], else bg.
REQ-031 HGRAD: pixel = x truncated or zero-extended to PIXEL_W.
REQ-032 Frame counter increments on frame_start and wraps modulo 2^FRAME_W.
REQ-033 If frame_start and line_start coincide, the line uses the incremented frame value.
REQ-034 line_start while busy: the current line is abandoned, overrun pulses, and the new line starts at x = 0 under REQ-024.
REQ-035 line_start with line_v >= V_PIXELS is ignored (no state change); in RENDER it still causes REQ-034 abandonment and returns to IDLE.
REQ-036 vram_addr and vram_d are 0 whenever vram_we = 0.

Reset
REQ-037 rst -> IDLE; vram_we, vram_addr, vram_d, busy, line_done and overrun = 0; frame counter = 0.
REQ-038 rst mid-line abandons the line with no further writes; line_start is ignored while rst is high.

Configuration
REQ-039 With SCANLINE_RENDERER_OVERRUN_CNT_EN defined: add output overrun_cnt (16 bits), which increments on each overrun pulse, saturates at 0xFFFF, and is cleared by rst.
REQ-040 Without SCANLINE_RENDERER_OVERRUN_CNT_EN: the overrun_cnt port and its logic are absent; all other behaviour is unchanged.

Verification
REQ-041 Defaults, grant held high, mode SOLID, fg 0xAA, line_start with line_v=5 -> 800 writes on vram_we=2'b10, addr 0..799, data 0xAA; line_done 801 cycles after line_start.
REQ-042 BAND, frame 0, line_v=100, fg 0xFF, bg 0x00 -> data 0xFF exactly for addr 11..233, 0x00 elsewhere; after one frame_start -> 0xFF for addr 10..232.
REQ-043 Grant low for 3 cycles while addr 7 is presented -> addr 7 and its data held stable for 4 cycles; total line length grows by 3 cycles.
REQ-044 line_start at addr 400 -> overrun pulse, next cycle addr 0 of the new line, a single line_done, overrun_cnt=1 with the macro defined.
REQ-045 line_v=600 -> no writes and no line_done; rst asserted at addr 50 -> all outputs 0 next cycle; HGRAD shows addr 300 data 0x2C.
